ksa_pipe_addsub: RTL
====================

# ksa_pipe_addsub

Parametrised, pipelined Kogge-Stone adder/subtractor: the next generation of the 32-bit combinational Kogge-Stone adder used in the FFT datapath. It provides generic operand width, configurable register insertion between prefix levels, an add/subtract mode, and signed-overflow reporting. A valid/ready handshake with full-pipeline stall and a sideband tag lets butterfly units issue back-to-back operations and track results under downstream backpressure.

## Interface
- WIDTH, 32: operand/sum width; must be at least 2, and need not be a power of two.
- PIPE_EVERY, 1: number of prefix levels per pipeline register group, in the range 1..LEVELS.
- TAG_W, 8: sideband tag width, at least 1.
- Derived: LEVELS = clog2(WIDTH); GROUPS = ceil(LEVELS/PIPE_EVERY); LAT = 1 + GROUPS.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in; used only when i_sub=0.
- i_sub  in  1  1 selects A - B, 0 selects A + B + i_cin.
- i_tag  in  TAG_W  sideband carried alongside the beat.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_s  out  WIDTH  sum/difference.
- o_carry  out  1  carry-out; in subtract mode it is the not-borrow flag.
- o_ovf  out  1  two's-complement signed overflow.
- o_tag  out  TAG_W  tag of the result beat.

## Operation
- Operand conditioning: b' = i_sub ? ~i_b : i_b; c0 = i_sub ? 1 : i_cin.
- Stage 0 is the input register. It captures p = a^b', g = a&b', c0, the tag, a[W-1], b'[W-1], and a valid bit.
- Carry-in is folded in as bit -1: g_-1 = c0, p_-1 = 0. This way the prefix computes carries into every bit, including the carry-in.
- Prefix: LEVELS Kogge-Stone levels with span 1, 2, 4, ... At each level, (G,P)[i] = (G[i] | P[i]&G[i-d], P[i]&P[i-d]) for i-d ≥ -1. Nodes without a predecessor pass through.
- The original p vector is carried unmodified through every register group.
- A register group is inserted after every PIPE_EVERY levels. The last group may contain fewer levels.
- The final group's register is the output register:
  - s[i] = p[i] ^ C[i-1], with C[-1] = c0.
  - o_carry = C[W-1].
  - o_ovf = C[W-1] ^ C[W-2].
- Handshake: adv = !o_valid | i_ready. o_ready = adv.
  - When adv=1, every stage loads its predecessor. Valid bits propagate, and bubbles also shift.
  - When adv=0, all stages hold, including data, tag, and valid.
- A beat is accepted when i_valid & o_ready. A result is consumed when o_valid & i_ready.
- Results leave strictly in input order. No beat is ever dropped or duplicated.
- Data/tag registers of invalid stages may hold stale values. o_s, o_carry, o_ovf, and o_tag are meaningful only when o_valid=1.

## Timing
- Latency: a beat accepted at edge k appears with o_valid=1 after edge k+LAT, provided adv=1 throughout. Examples: WIDTH=32, PIPE_EVERY=1 gives LAT=6; PIPE_EVERY=5 gives LAT=2; WIDTH=24, PIPE_EVERY=2 gives LAT=4.
- Throughput: one beat per cycle while i_ready=1.
- Stall: each cycle with o_valid=1 and i_ready=0 delays every in-flight beat by exactly one cycle.
- o_ready is combinational from i_ready and o_valid. There is no combinational path from i_valid to o_ready.
- Reset (i_rst=1 at an edge) clears all stage valid bits, o_s, o_carry, o_ovf, and o_tag to 0. After reset, o_valid=0 and o_ready=1.
- Reset mid-operation discards all in-flight beats. Inputs presented during the reset cycle are not accepted.
- Simultaneous events: consume and accept in the same cycle are legal. The pipeline then shifts by one with no bubble inserted.

## Test plan
- Add, WIDTH=32, PIPE_EVERY=1: a=0xFFFFFFFF, b=0x00000001, cin=0, tag=0x5A -> o_s=0x00000000, o_carry=1, o_ovf=0, o_tag=0x5A. o_valid rises exactly 6 cycles after acceptance.
- Subtract: a=0x80000000, b=0x00000001, sub=1 -> o_s=0x7FFFFFFF, o_carry=1, o_ovf=1. Second case a=3, b=5, sub=1 -> o_s=0xFFFFFFFE, o_carry=0, o_ovf=0.
- Carry-in path, WIDTH=24, PIPE_EVERY=2: a=0x7FFFFF, b=0, cin=1 -> o_s=0x800000, o_ovf=1, o_carry=0. Latency is 4.
- Backpressure: stream 20 beats with tags 0..19 at full rate. Hold i_ready=0 for cycles 8-12, then toggle i_ready every cycle. Required: results match a golden model in order, tags are 0..19 each exactly once, and o_ready=0 exactly when o_valid=1 and i_ready=0.
- Reset mid-stream: reset asserted with 4 beats in flight -> o_valid=0 on the next cycle and no stale result appears afterwards. The first beat after reset completes in LAT cycles.
- Random regression: 10k random operands, modes, and stalls for WIDTH∈{8,17,32,64} and PIPE_EVERY∈{1,2,LEVELS}, checked against a behavioural {carry,sum} model and the overflow formula.

Source files
------------

// File: rtl/ksa_pipe_addsub_if.sv
// Beat-level bundle for ksa_pipe_addsub: operands, mode, tag and the
// valid/ready pairs on both the input and the result side.
interface ksa_pipe_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             i_sub;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_s;
    logic             o_carry;
    logic             o_ovf;
    logic [TAG_W-1:0] o_tag;

    modport master (
        output i_valid, i_a, i_b, i_cin, i_sub, i_tag, i_ready,
        input  o_ready, o_valid, o_s, o_carry, o_ovf, o_tag
    );

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_sub, i_tag, i_ready,
        output o_ready, o_valid, o_s, o_carry, o_ovf, o_tag
    );
endinterface

// File: rtl/ksa_pipe_addsub.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in folded in as bit -1,
// a register after every PIPE_EVERY prefix levels and a whole-pipe stall.
module ksa_pipe_addsub #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 1,
    parameter int TAG_W      = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    ksa_pipe_addsub_if.slave  bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int GROUPS = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

    // Index 0 of every extended (WIDTH+1) vector is the carry-in node.
    function automatic logic [WIDTH:0] full_carries(input logic [WIDTH:0] g,
                                                    input logic [WIDTH:0] p);
        // When WIDTH is a power of two the top node's span stops just short
        // of the carry-in node; nodes that do reach it have p=0, so this is exact.
        return g | (p & {(WIDTH+1){g[0]}});
    endfunction

    function automatic logic signed_ovf(input logic [WIDTH:0] c);
        return c[WIDTH] ^ c[WIDTH-1];
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic             c0;

    assign adv         = !bus.o_valid | bus.i_ready;
    assign bus.o_ready = adv;
    assign b_cond      = bus.i_sub ? ~bus.i_b : bus.i_b;
    assign c0          = bus.i_sub | bus.i_cin;

    for (genvar k = 0; k < GROUPS; k++) begin : g_stg
        logic [WIDTH:0]   gen_d, prp_d, gen_pn, prp_pn;
        logic [WIDTH-1:0] p_d, p_pn;
        logic [TAG_W-1:0] tag_d, tag_pn;
        logic             vld_d, vld_pn;

        if (k == 0) begin : g_in
            assign gen_d = {bus.i_a & b_cond, c0};
            assign prp_d = {bus.i_a ^ b_cond, 1'b0};
            assign p_d   = bus.i_a ^ b_cond;
            assign tag_d = bus.i_tag;
            assign vld_d = bus.i_valid;
        end else begin : g_mid
            assign gen_d = g_lvl[k*PIPE_EVERY-1].g_o;
            assign prp_d = g_lvl[k*PIPE_EVERY-1].p_o;
            assign p_d   = g_stg[k-1].p_pn;
            assign tag_d = g_stg[k-1].tag_pn;
            assign vld_d = g_stg[k-1].vld_pn;
        end

        // ---- stage k register boundary ----
        always_ff @(posedge i_clk) begin
            if (adv) begin
                gen_pn <= gen_d;
                prp_pn <= prp_d;
                p_pn   <= p_d;
                tag_pn <= tag_d;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_pn <= 1'b0;
            end else if (adv) begin
                vld_pn <= vld_d;
            end
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int D = 1 << l;
        logic [WIDTH:0] g_i, p_i, g_o, p_o;

        if (l % PIPE_EVERY == 0) begin : g_from_reg
            assign g_i = g_stg[l/PIPE_EVERY].gen_pn;
            assign p_i = g_stg[l/PIPE_EVERY].prp_pn;
        end else begin : g_from_lvl
            assign g_i = g_lvl[l-1].g_o;
            assign p_i = g_lvl[l-1].p_o;
        end

        assign g_o[D-1:0]     = g_i[D-1:0];
        assign p_o[D-1:0]     = p_i[D-1:0];
        assign g_o[WIDTH:D]   = g_i[WIDTH:D] | (p_i[WIDTH:D] & g_i[WIDTH-D:0]);
        assign p_o[WIDTH:D]   = p_i[WIDTH:D] & p_i[WIDTH-D:0];
    end

    logic [WIDTH:0] carries;
    assign carries = full_carries(g_lvl[LEVELS-1].g_o, g_lvl[LEVELS-1].p_o);

    // ---- output register boundary ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_valid <= 1'b0;
            bus.o_s     <= '0;
            bus.o_carry <= 1'b0;
            bus.o_ovf   <= 1'b0;
            bus.o_tag   <= '0;
        end else if (adv) begin
            bus.o_valid <= g_stg[GROUPS-1].vld_pn;
            bus.o_s     <= g_stg[GROUPS-1].p_pn ^ carries[WIDTH-1:0];
            bus.o_carry <= carries[WIDTH];
            bus.o_ovf   <= signed_ovf(carries);
            bus.o_tag   <= g_stg[GROUPS-1].tag_pn;
        end
    end
endmodule
